// File: rtl/fsm_pkg.sv
// Shared definitions for the fast-gate conditioner: FSM state encoding,
// default timing windows and a small window-compare helper.
package fsm_pkg;

    typedef enum logic [1:0] {
        FG_IDLE   = 2'd0,
        FG_FIRST  = 2'd1,
        FG_LOCKED = 2'd2,
        FG_LOST   = 2'd3
    } fg_state_t;

    localparam int DEF_DEBOUNCE_CYCLES = 4;
    localparam int DEF_CNT_W           = 24;
    localparam int DEF_PERIOD_MIN      = 1_900_000;
    localparam int DEF_PERIOD_MAX      = 2_100_000;
    localparam int DEF_WIDTH_MIN       = 18_000;
    localparam int DEF_WIDTH_MAX       = 22_000;

    // Inclusive window test on zero-extended counter values.
    function automatic logic in_window(input logic [31:0] value,
                                       input logic [31:0] lo,
                                       input logic [31:0] hi);
        return (value >= lo) && (value <= hi);
    endfunction

endpackage

// File: rtl/debounce_sync.sv
// Two-flop synchronizer followed by a stability debouncer. The clean level
// follows the synchronized input only after DEBOUNCE_CYCLES consecutive
// cycles of disagreement; a single agreeing cycle restarts the count.
module debounce_sync #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clock,
    input  logic reset_signal,
    input  logic raw,
    output logic clean
);

    localparam int              CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync_r;
    logic [CW-1:0] stable_cnt_r;

    // Synchronize the raw input and debounce the synchronized level.
    always_ff @(posedge clock) begin
        if (!reset_signal) begin
            sync_r       <= 2'b00;
            stable_cnt_r <= '0;
            clean        <= 1'b0;
        end else begin
            sync_r <= {sync_r[0], raw};
            if (sync_r[1] != clean) begin
                if (stable_cnt_r == CNT_LAST) begin
                    clean        <= sync_r[1];
                    stable_cnt_r <= '0;
                end else begin
                    stable_cnt_r <= stable_cnt_r + CW'(1);
                end
            end else begin
                stable_cnt_r <= '0;
            end
        end
    end

endmodule

// File: rtl/fg_conditioner.sv
// Fast-gate conditioner: cleans the opto and start inputs, measures the gate
// period and open width, and tracks lock on the gate timing. Qualified rise
// pulses are only passed on while the gate timing is locked.
module fg_conditioner
    import fsm_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int CNT_W           = DEF_CNT_W,
    parameter int PERIOD_MIN      = DEF_PERIOD_MIN,
    parameter int PERIOD_MAX      = DEF_PERIOD_MAX,
    parameter int WIDTH_MIN       = DEF_WIDTH_MIN,
    parameter int WIDTH_MAX       = DEF_WIDTH_MAX
) (
    input  logic             clock,
    input  logic             reset_signal,
    input  logic             fg_raw,
    input  logic             start_raw,
    output logic             fg_clean,
    output logic             start_clean,
    output logic             fg_rise,
    output logic             fg_qualified,
    output logic [CNT_W-1:0] period_out,
    output logic [CNT_W-1:0] width_out,
    output logic [1:0]       fg_state,
    output logic             fg_lost
);

    // The period counter parks one past the window; that value doubles as
    // the loss timeout and as the period reported for a late rise.
    localparam logic [CNT_W-1:0] PER_LIMIT = CNT_W'(PERIOD_MAX + 1);
    localparam logic [CNT_W-1:0] WID_SAT   = {CNT_W{1'b1}};

    fg_state_t        state_r;
    fg_state_t        state_next_s;
    logic             clean_d_r;
    logic             fg_fall_s;
    logic [CNT_W-1:0] per_cnt_r;
    logic [CNT_W-1:0] wid_cnt_r;
    logic             per_ok_s;
    logic             wid_ok_s;
    logic             timeout_s;

    debounce_sync #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_fg_db (
        .clock        (clock),
        .reset_signal (reset_signal),
        .raw          (fg_raw),
        .clean        (fg_clean)
    );

    debounce_sync #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_start_db (
        .clock        (clock),
        .reset_signal (reset_signal),
        .raw          (start_raw),
        .clean        (start_clean)
    );

    // Edges are decoded from the debounced level and its one-cycle history so
    // the rise pulse coincides with the first cycle fg_clean reads 1.
    assign fg_rise   = fg_clean & ~clean_d_r;
    assign fg_fall_s = ~fg_clean & clean_d_r;

    assign per_ok_s  = in_window(32'(per_cnt_r), 32'(PERIOD_MIN), 32'(PERIOD_MAX));
    assign wid_ok_s  = in_window(32'(wid_cnt_r), 32'(WIDTH_MIN), 32'(WIDTH_MAX));
    assign timeout_s = (per_cnt_r == PER_LIMIT);

    // A rise is qualified only if it keeps an already locked gate locked.
    assign fg_qualified = fg_rise & (state_r == FG_LOCKED) & per_ok_s;
    assign fg_state     = state_r;

    // Track the previous debounced level for edge decoding.
    always_ff @(posedge clock) begin
        if (!reset_signal) begin
            clean_d_r <= 1'b0;
        end else begin
            clean_d_r <= fg_clean;
        end
    end

    // Rise-to-rise period counter with saturation; latch the period on rise.
    always_ff @(posedge clock) begin
        if (!reset_signal) begin
            per_cnt_r  <= '0;
            period_out <= '0;
        end else if (fg_rise) begin
            per_cnt_r <= CNT_W'(1);
            if (state_r != FG_IDLE) begin
                period_out <= per_cnt_r;
            end
        end else if (per_cnt_r != PER_LIMIT) begin
            per_cnt_r <= per_cnt_r + CNT_W'(1);
        end
    end

    // Gate-open width counter; latch the width on the falling edge.
    always_ff @(posedge clock) begin
        if (!reset_signal) begin
            wid_cnt_r <= '0;
            width_out <= '0;
        end else if (fg_clean) begin
            if (wid_cnt_r != WID_SAT) begin
                wid_cnt_r <= wid_cnt_r + CNT_W'(1);
            end
        end else if (fg_fall_s) begin
            width_out <= wid_cnt_r;
            wid_cnt_r <= '0;
        end
    end

    // Lock-tracking next-state logic; a rise wins over a same-cycle timeout
    // and is then judged on the saturated (out-of-window) period.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            FG_IDLE: begin
                if (fg_rise) state_next_s = FG_FIRST;
                else         state_next_s = FG_IDLE;
            end
            FG_FIRST: begin
                if (fg_rise)        state_next_s = per_ok_s ? FG_LOCKED : FG_LOST;
                else if (timeout_s) state_next_s = FG_LOST;
                else                state_next_s = FG_FIRST;
            end
            FG_LOCKED: begin
                if (fg_rise)                    state_next_s = per_ok_s ? FG_LOCKED : FG_LOST;
                else if (fg_fall_s && !wid_ok_s) state_next_s = FG_LOST;
                else if (timeout_s)             state_next_s = FG_LOST;
                else                            state_next_s = FG_LOCKED;
            end
            FG_LOST: begin
                if (fg_rise) state_next_s = FG_FIRST;
                else         state_next_s = FG_LOST;
            end
            default: state_next_s = FG_IDLE;
        endcase
    end

    // State register and the registered loss indicator.
    always_ff @(posedge clock) begin
        if (!reset_signal) begin
            state_r <= FG_IDLE;
            fg_lost <= 1'b0;
        end else begin
            state_r <= state_next_s;
            fg_lost <= (state_next_s == FG_LOST);
        end
    end

endmodule

// File: tb/tb_fg_conditioner.sv
// Directed bench for fg_conditioner with small simulation windows.
module tb_fg_conditioner;

    logic        clock = 1'b0;
    logic        reset_signal;
    logic        fg_raw;
    logic        start_raw;
    logic        fg_clean;
    logic        start_clean;
    logic        fg_rise;
    logic        fg_qualified;
    logic [15:0] period_out;
    logic [15:0] width_out;
    logic [1:0]  fg_state;
    logic        fg_lost;

    int total = 0;
    int bad   = 0;

    // Values captured by the pulse task at fixed offsets.
    int          rises;
    int          quals_post;
    logic        q_rise, r_rise, lost_a, lost_b;
    logic [1:0]  st_rise, st_fall;
    logic [15:0] per_rise, wid_fall;

    fg_conditioner #(
        .DEBOUNCE_CYCLES (4),
        .CNT_W           (16),
        .PERIOD_MIN      (100),
        .PERIOD_MAX      (200),
        .WIDTH_MIN       (10),
        .WIDTH_MAX       (50)
    ) dut (
        .clock        (clock),
        .reset_signal (reset_signal),
        .fg_raw       (fg_raw),
        .start_raw    (start_raw),
        .fg_clean     (fg_clean),
        .start_clean  (start_clean),
        .fg_rise      (fg_rise),
        .fg_qualified (fg_qualified),
        .period_out   (period_out),
        .width_out    (width_out),
        .fg_state     (fg_state),
        .fg_lost      (fg_lost)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_state"},  int'(fg_state), 0);
        check({tag, "_clean"},  int'(fg_clean), 0);
        check({tag, "_start"},  int'(start_clean), 0);
        check({tag, "_rise"},   int'(fg_rise), 0);
        check({tag, "_qual"},   int'(fg_qualified), 0);
        check({tag, "_period"}, int'(period_out), 0);
        check({tag, "_width"},  int'(width_out), 0);
        check({tag, "_lost"},   int'(fg_lost), 0);
    endtask

    // One raw gate pulse: high for w cycles, next pulse starts after gap
    // cycles. With a clean raw step the debounced edges trail by 6 cycles,
    // so the rise is seen at offset 6 and its effects at offset 7.
    task automatic pulse(input int w, input int gap, input int rst_at);
        fg_raw     = 1'b1;
        rises      = 0;
        quals_post = 0;
        for (int i = 1; i <= gap; i++) begin
            @(negedge clock);
            if (fg_rise) rises++;
            if (rst_at > 0 && i > rst_at && fg_qualified) quals_post++;
            if (i == 6) begin
                q_rise = fg_qualified;
                r_rise = fg_rise;
            end
            if (i == 7) begin
                st_rise  = fg_state;
                per_rise = period_out;
            end
            if (i == w + 7) begin
                st_fall  = fg_state;
                wid_fall = width_out;
            end
            if (i == 207) lost_a = fg_lost;
            if (i == 208) lost_b = fg_lost;
            if (rst_at > 0 && i == rst_at + 1) begin
                check_all_zero("midreset");
                reset_signal = 1'b1;
            end
            if (rst_at > 0 && i == rst_at) reset_signal = 1'b0;
            if (i == w) fg_raw = 1'b0;
        end
    endtask

    initial begin
        reset_signal = 1'b0;
        fg_raw       = 1'b0;
        start_raw    = 1'b0;
        repeat (3) @(negedge clock);
        check_all_zero("reset");
        reset_signal = 1'b1;
        @(negedge clock);

        // Clean step on start: debounced edge exactly 6 cycles later.
        start_raw = 1'b1;
        repeat (5) @(negedge clock);
        check("start_lat5", int'(start_clean), 0);
        @(negedge clock);
        check("start_lat6", int'(start_clean), 1);

        // Bouncy fg step: three 1-cycle glitches, then stable high.
        rises = 0;
        for (int g = 0; g < 6; g++) begin
            fg_raw = ((g % 2) == 0);
            @(negedge clock);
            if (fg_rise) rises++;
        end
        fg_raw = 1'b1;
        repeat (5) begin
            @(negedge clock);
            if (fg_rise) rises++;
        end
        check("bounce_no_early_rise", rises, 0);
        @(negedge clock);
        check("bounce_rise_at_6", int'(fg_rise), 1);
        @(negedge clock);
        check("bounce_state_first", int'(fg_state), 1);
        rises = 0;
        repeat (10) begin
            @(negedge clock);
            if (fg_rise) rises++;
        end
        check("bounce_single_rise", rises, 0);

        // Reset again to start the lock sequence from IDLE.
        fg_raw       = 1'b0;
        reset_signal = 1'b0;
        repeat (10) @(negedge clock);
        reset_signal = 1'b1;
        @(negedge clock);
        check("rereset_state", int'(fg_state), 0);

        // Three in-window pulses: IDLE -> FIRST -> LOCKED, third qualified.
        pulse(20, 150, 0);
        check("p1_rise", int'(r_rise), 1);
        check("p1_qual", int'(q_rise), 0);
        check("p1_state", int'(st_rise), 1);
        check("p1_period", int'(per_rise), 0);
        check("p1_width", int'(wid_fall), 20);
        check("p1_rises", rises, 1);
        pulse(20, 150, 0);
        check("p2_qual", int'(q_rise), 0);
        check("p2_state", int'(st_rise), 2);
        check("p2_period", int'(per_rise), 150);
        pulse(20, 150, 0);
        check("p3_qual", int'(q_rise), 1);
        check("p3_state", int'(st_rise), 2);
        check("p3_period", int'(per_rise), 150);
        check("p3_width", int'(wid_fall), 20);

        // Late rise: lost once the counter reaches 201.
        pulse(20, 250, 0);
        check("p4_qual", int'(q_rise), 1);
        check("p4_lost_before", int'(lost_a), 0);
        check("p4_lost_after", int'(lost_b), 1);
        pulse(20, 150, 0);
        check("p5_qual", int'(q_rise), 0);
        check("p5_state", int'(st_rise), 1);
        check("p5_period", int'(per_rise), 201);
        check("p5_lost_clear", int'(fg_lost), 0);
        pulse(20, 150, 0);
        check("p6_qual", int'(q_rise), 0);
        check("p6_state", int'(st_rise), 2);
        pulse(20, 150, 0);
        check("p7_qual", int'(q_rise), 1);

        // Over-wide gate: lost on the fall, next rise unqualified.
        pulse(60, 150, 0);
        check("p8_qual", int'(q_rise), 1);
        check("p8_state_rise", int'(st_rise), 2);
        check("p8_state_fall", int'(st_fall), 3);
        check("p8_width", int'(wid_fall), 60);
        pulse(20, 150, 0);
        check("p9_qual", int'(q_rise), 0);
        check("p9_state", int'(st_rise), 1);
        check("p9_period", int'(per_rise), 150);
        pulse(20, 150, 0);
        pulse(20, 150, 0);
        check("p11_qual", int'(q_rise), 1);

        // One-cycle reset while the gate is open in LOCKED.
        pulse(20, 150, 12);
        check("p12_qual_pre", int'(q_rise), 1);
        check("p12_quals_post", quals_post, 0);
        check("p12_rises", rises, 2);
        check("p12_state_end", int'(fg_state), 1);
        check("p12_period_end", int'(period_out), 0);
        check("p12_width", int'(wid_fall), 7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
